shift_ram_burst: RTL
====================

Name: shift_ram_burst

Overview:
- Parametrised RAM-based delay-line and history-readout block for the correlator datapath.
- Each accepted sample is written into a circular RAM. The block then streams a burst of the last LAGS samples, newest first, each tagged with its lag index, to the multiply-accumulate stage.
- Generalises the fixed 8-bit/64-word shift RAM. Adds a configurable burst length, a valid/first/last framing, fill-level masking, a busy flag and an overrun report.

Parameters:
- DW, 8, data width in bits.
- AW, 6, address width; DEPTH = 2**AW words.
- LAGS, 64, words read per burst; legal range 1..DEPTH.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- din  in  DW  sample input.
- sin  in  1  sample strobe; single-cycle pulse.
- dout  out  DW  last accepted sample, held.
- sout  out  1  one-cycle pulse: dout updated.
- dshift  out  DW  history word; 0 when dvalid=0.
- dvalid  out  1  dshift/dlag valid.
- dlag  out  AW  lag index of dshift (0 = newest).
- dfirst  out  1  dvalid for lag 0.
- dlast  out  1  dvalid for lag LAGS-1.
- busy  out  1  burst in progress (state != IDLE).
- ovf  out  1  one-cycle pulse: sin dropped.
- clr  in  1  synchronous clear; port exists only with SHIFT_CLR_EN.

Behaviour:
- Reset values:
  - All outputs are 0.
  - wr_ptr = 0, fill = 0, rd_idx = 0, state = IDLE.
  - RAM contents are not reset. Fill masking guarantees zeros are read instead.
- RAM: DEPTH x DW, synchronous write, synchronous read (1-cycle), inferable as block RAM.
- State machine: IDLE, RD.
- IDLE with sin=1, cycle T (accept):
  - ram[wr_ptr] <= din; wr_ptr <= wr_ptr+1 (wraps mod DEPTH).
  - fill <= min(fill+1, DEPTH); dout <= din.
  - rd_idx <= 0; state <= RD.
  - sout=1 in cycle T+1.
- RD with rd_idx=k:
  - Read address = wr_ptr-1-k (mod DEPTH).
  - Output pipeline register presents dshift/dlag=k/dvalid=1 in the next cycle.
  - rd_idx increments each cycle. After k = LAGS-1 is issued, state <= IDLE.
- Latency and burst shape:
  - Lag 0 appears at T+2; lag LAGS-1 at T+1+LAGS.
  - dvalid is contiguous for exactly LAGS cycles.
  - dfirst and dlast coincide when LAGS=1.
- Fill masking: when k >= fill, dshift = 0 with dvalid still 1. The burst length is always LAGS.
- Overrun:
  - sin while state=RD: sample not written, dout/fill/wr_ptr unchanged.
  - ovf=1 in the next cycle; the burst continues undisturbed.
- Back-to-back: sin is accepted in the first IDLE cycle after the burst, while the final word is still in the output register. Minimum accepted sin spacing is LAGS+1 cycles.
- Wrap-around: addresses are modulo DEPTH. Once fill=DEPTH, writes overwrite the oldest word.
- Async reset mid-burst: outputs drop to 0 immediately; the burst is abandoned.

Optional Feature:
- SHIFT_CLR_EN defined:
  - clr port present. clr=1 at an edge forces wr_ptr=0, fill=0, state=IDLE, dout=0, and clears the output register next cycle.
  - A burst in progress is aborted (dvalid drops next cycle; no dlast).
  - clr has priority over a simultaneous sin; that sample is discarded, with no ovf.
- SHIFT_CLR_EN undefined: no clr port; the contents are cleared only by rst_n.

Test Plan:
- Defaults, after reset: sin with din=8'h11 -> sout at T+1, dout=8'h11. dvalid for T+2..T+65, dlag 0..63, dshift=11 at lag 0 then zeros; dfirst at T+2, dlast at T+65.
- 70 samples din=1..70, spacing 65 -> burst after the last sample: dshift=70,69,...,7 at lags 0..63 (wrap verified).
- LAGS=4, samples A,B,C -> third burst: C,B,A,0; busy high for 4 cycles per burst.
- sin 10 cycles after an accept -> ovf pulse one cycle later; the next burst shows the dropped sample absent.
- sin exactly LAGS+1 cycles after the previous accept -> accepted, no ovf, bursts contiguous without gap glitches.
- SHIFT_CLR_EN: clr mid-burst at lag 20 -> dvalid low the next cycle. The next sample's burst returns that sample at lag 0 then zeros.

Source files
------------

// File: rtl/shift_ram_burst_if.sv
// shift_ram_burst_if: sample input, held-sample output and burst history bus
// of the correlator delay line. The slave modport is the delay line itself;
// the master modport is whoever feeds samples and consumes the burst.
interface shift_ram_burst_if #(
    parameter int DW = 8,
    parameter int AW = 6
);
    logic [DW-1:0] din;
    logic          sin;
    logic [DW-1:0] dout;
    logic          sout;
    logic [DW-1:0] dshift;
    logic          dvalid;
    logic [AW-1:0] dlag;
    logic          dfirst;
    logic          dlast;
    logic          busy;
    logic          ovf;

    modport master (
        output din, sin,
        input  dout, sout, dshift, dvalid, dlag, dfirst, dlast, busy, ovf
    );

    modport slave (
        input  din, sin,
        output dout, sout, dshift, dvalid, dlag, dfirst, dlast, busy, ovf
    );
endinterface

// File: rtl/shift_ram_burst.sv
// shift_ram_burst: RAM-based delay line for the correlator. Every accepted
// sample goes into a circular DEPTH-word RAM, then the last LAGS samples are
// streamed out newest first, tagged with their lag index. Lags beyond the
// current fill level read as zero, so the RAM itself never needs clearing.
// A sample strobe arriving while a burst is running is dropped and flagged.
// Optional feature macro: SHIFT_CLR_EN adds a synchronous clear input 'clr'.
module shift_ram_burst #(
    parameter int DW   = 8,
    parameter int AW   = 6,
    parameter int LAGS = 64
) (
    input  logic clk,
    input  logic rst_n,
`ifdef SHIFT_CLR_EN
    input  logic clr,
`endif
    shift_ram_burst_if.slave bus
);
    localparam int            DEPTH    = 1 << AW;
    localparam logic [AW-1:0] LAST_IDX = AW'(LAGS - 1);
    localparam logic [AW:0]   FULL     = (AW+1)'(DEPTH);

    typedef enum logic {
        IDLE,
        RD
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic          accept;
    logic          issue;
    logic          drop;
    logic          clr_i;

    logic [AW-1:0] wr_ptr;
    logic [AW:0]   fill;
    logic [AW-1:0] rd_idx;
    logic [AW-1:0] rd_addr;

    logic [DW-1:0] ram [DEPTH];
    logic [DW-1:0] ram_q;

    logic [DW-1:0] dout_q;
    logic          sout_q;
    logic          ovf_q;
    logic          dvalid_q;
    logic [AW-1:0] dlag_q;
    logic          mask_q;

`ifdef SHIFT_CLR_EN
    assign clr_i = clr;
`else
    assign clr_i = 1'b0;
`endif

    // Lag k lives k words behind the most recently written slot.
    assign rd_addr = wr_ptr - AW'(1) - rd_idx;

    // Next-state logic: accept a sample in IDLE, issue one read per cycle in RD; clear wins over everything.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        issue   = 1'b0;
        drop    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.sin) begin
                    accept  = 1'b1;
                    state_d = RD;
                end
            end
            RD: begin
                issue = 1'b1;
                drop  = bus.sin;
                if (rd_idx == LAST_IDX) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (clr_i) begin
            state_d = IDLE;
            accept  = 1'b0;
            issue   = 1'b0;
            drop    = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Write pointer, fill level, lag counter and the output pipeline register that travels with the RAM read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            fill     <= '0;
            rd_idx   <= '0;
            dout_q   <= '0;
            sout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            dvalid_q <= 1'b0;
            dlag_q   <= '0;
            mask_q   <= 1'b0;
        end else if (clr_i) begin
            wr_ptr   <= '0;
            fill     <= '0;
            rd_idx   <= '0;
            dout_q   <= '0;
            sout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            dvalid_q <= 1'b0;
            dlag_q   <= '0;
            mask_q   <= 1'b0;
        end else begin
            sout_q   <= accept;
            ovf_q    <= drop;
            dvalid_q <= issue;
            dlag_q   <= issue ? rd_idx : '0;
            mask_q   <= issue && ({1'b0, rd_idx} >= fill);
            if (accept) begin
                wr_ptr <= wr_ptr + AW'(1);
                fill   <= (fill == FULL) ? FULL : fill + (AW+1)'(1);
                dout_q <= bus.din;
                rd_idx <= '0;
            end else if (issue) begin
                rd_idx <= rd_idx + AW'(1);
            end
        end
    end

    // RAM write port; contents are deliberately not reset so this maps onto block RAM.
    always_ff @(posedge clk) begin
        if (accept) begin
            ram[wr_ptr] <= bus.din;
        end
    end

    // RAM synchronous read port; its register is the data half of the output pipeline stage.
    always_ff @(posedge clk) begin
        if (issue) begin
            ram_q <= ram[rd_addr];
        end
    end

    assign bus.dout   = dout_q;
    assign bus.sout   = sout_q;
    assign bus.ovf    = ovf_q;
    assign bus.dvalid = dvalid_q;
    assign bus.dlag   = dlag_q;
    assign bus.dshift = (dvalid_q && !mask_q) ? ram_q : '0;
    assign bus.dfirst = dvalid_q && (dlag_q == '0);
    assign bus.dlast  = dvalid_q && (dlag_q == LAST_IDX);
    assign bus.busy   = (state_q != IDLE);
endmodule
